// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32/RV64 instruction decode stage with a one-entry
//               skid buffer. Optional counters enabled by DECODE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int XLEN        = 32,
    parameter bit SYSTEM_AS_I = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_type,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]     stat_count_r,
    output logic [31:0]     stat_count_i,
    output logic [31:0]     stat_count_s,
    output logic [31:0]     stat_count_b,
    output logic [31:0]     stat_count_u,
    output logic [31:0]     stat_count_j,
    output logic [31:0]     stat_count_illegal
`endif
);

    localparam logic [5:0] c_TYPE_R = 6'b100000;
    localparam logic [5:0] c_TYPE_I = 6'b010000;
    localparam logic [5:0] c_TYPE_S = 6'b001000;
    localparam logic [5:0] c_TYPE_B = 6'b000100;
    localparam logic [5:0] c_TYPE_U = 6'b000010;
    localparam logic [5:0] c_TYPE_J = 6'b000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [5:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    logic [4:0]      w_op;
    logic [5:0]      w_type;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    bundle_t         w_dec;

    bundle_t         r_or;
    bundle_t         r_sk;
    logic            r_or_valid;
    logic            r_sk_valid;

    assign w_op = in_instr[6:2];

    always_comb begin
        w_type = 6'b000000;
        if (in_instr[1:0] == 2'b11) begin
            case (w_op)
                5'b01100, 5'b01011, 5'b01110, 5'b10100: w_type = c_TYPE_R;
                5'b00000, 5'b00001, 5'b00010, 5'b00011,
                5'b00100, 5'b00110, 5'b00111, 5'b11001:  w_type = c_TYPE_I;
                5'b11100: w_type = SYSTEM_AS_I ? c_TYPE_I : 6'b000000;
                5'b01000, 5'b01001:                      w_type = c_TYPE_S;
                5'b11000:                                w_type = c_TYPE_B;
                5'b00101, 5'b01101:                      w_type = c_TYPE_U;
                5'b11011:                                w_type = c_TYPE_J;
                default:                                 w_type = 6'b000000;
            endcase
        end
    end

    // Immediate assembled at 32 bits, then widened to XLEN below.
    always_comb begin
        w_imm32 = 32'd0;
        if (w_type == c_TYPE_I) begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end else if (w_type == c_TYPE_S) begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end else if (w_type == c_TYPE_B) begin
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        end else if (w_type == c_TYPE_U) begin
            w_imm32 = {in_instr[31:12], 12'd0};
        end else if (w_type == c_TYPE_J) begin
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
        end
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.typ     = w_type;
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.funct3  = in_instr[14:12];
        w_dec.funct7  = in_instr[31:25];
        w_dec.imm     = w_imm;
        w_dec.illegal = (w_type == 6'b000000);
    end

    // in_ready depends only on skid occupancy, never on out_ready.
    assign in_ready = !r_sk_valid;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or       <= '0;
            r_sk       <= '0;
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (flush) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (!r_or_valid || out_ready) begin
            if (r_sk_valid) begin
                r_or       <= r_sk;
                r_or_valid <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_or       <= w_dec;
                r_or_valid <= 1'b1;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk       <= w_dec;
            r_sk_valid <= 1'b1;
        end
    end

    assign out_valid   = r_or_valid;
    assign out_pc      = r_or.pc;
    assign out_type    = r_or.typ;
    assign out_rd      = r_or.rd;
    assign out_rs1     = r_or.rs1;
    assign out_rs2     = r_or.rs2;
    assign out_funct3  = r_or.funct3;
    assign out_funct7  = r_or.funct7;
    assign out_imm     = r_or.imm;
    assign out_illegal = r_or.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] r_stat [7];
    logic [6:0]  w_hit;

    // Index 6..1 follow out_type (r..j), index 0 is illegal.
    assign w_hit = {r_or.typ, r_or.illegal};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) begin
                r_stat[k] <= 32'd0;
            end
        end else if (!flush && r_or_valid && out_ready) begin
            for (int k = 0; k < 7; k++) begin
                if (w_hit[k] && (r_stat[k] != 32'hFFFF_FFFF)) begin
                    r_stat[k] <= r_stat[k] + 32'd1;
                end
            end
        end
    end

    assign stat_count_r       = r_stat[6];
    assign stat_count_i       = r_stat[5];
    assign stat_count_s       = r_stat[4];
    assign stat_count_b       = r_stat[3];
    assign stat_count_u       = r_stat[2];
    assign stat_count_j       = r_stat[1];
    assign stat_count_illegal = r_stat[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage (RV32 with SYSTEM_AS_I=1
//               and RV64 with SYSTEM_AS_I=0); DECODE_STATS_EN optional.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        r32_ready, r32_valid, r32_ill;
    logic [31:0] r32_pc, r32_imm;
    logic [5:0]  r32_type;
    logic [4:0]  r32_rd, r32_rs1, r32_rs2;
    logic [2:0]  r32_f3;
    logic [6:0]  r32_f7;

    logic        r64_ready, r64_valid, r64_ill;
    logic [63:0] r64_pc, r64_imm;
    logic [5:0]  r64_type;
    logic [4:0]  r64_rd, r64_rs1, r64_rs2;
    logic [2:0]  r64_f3;
    logic [6:0]  r64_f7;

`ifdef DECODE_STATS_EN
    logic [31:0] s32 [7];
    logic [31:0] s64 [7];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    decode_stage #(.XLEN(32), .SYSTEM_AS_I(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(r32_valid), .out_ready(out_ready), .out_pc(r32_pc), .out_type(r32_type),
        .out_rd(r32_rd), .out_rs1(r32_rs1), .out_rs2(r32_rs2), .out_funct3(r32_f3),
        .out_funct7(r32_f7), .out_imm(r32_imm), .out_illegal(r32_ill)
`ifdef DECODE_STATS_EN
        , .stat_count_r(s32[0]), .stat_count_i(s32[1]), .stat_count_s(s32[2]),
        .stat_count_b(s32[3]), .stat_count_u(s32[4]), .stat_count_j(s32[5]),
        .stat_count_illegal(s32[6])
`endif
    );

    decode_stage #(.XLEN(64), .SYSTEM_AS_I(1'b0)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(r64_valid), .out_ready(out_ready), .out_pc(r64_pc), .out_type(r64_type),
        .out_rd(r64_rd), .out_rs1(r64_rs1), .out_rs2(r64_rs2), .out_funct3(r64_f3),
        .out_funct7(r64_f7), .out_imm(r64_imm), .out_illegal(r64_ill)
`ifdef DECODE_STATS_EN
        , .stat_count_r(s64[0]), .stat_count_i(s64[1]), .stat_count_s(s64[2]),
        .stat_count_b(s64[3]), .stat_count_u(s64[4]), .stat_count_j(s64[5]),
        .stat_count_illegal(s64[6])
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  typ;
        logic        illegal;
        logic [63:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } txn_t;

    txn_t        q[$];
    int unsigned m32 [7];
    int unsigned m64 [7];

    // Reference decode: immediate as a signed integer value, truncated to XLEN.
    function automatic exp_t model(logic [31:0] ins, bit sys_i, int xlen);
        exp_t       e;
        logic [4:0] op;
        longint     v;
        op    = ins[6:2];
        e.typ = 6'b000000;
        v     = 0;
        if (ins[1:0] == 2'b11) begin
            if (op inside {5'b01100, 5'b01011, 5'b01110, 5'b10100}) begin
                e.typ = 6'b100000;
            end else if ((op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                     5'b00100, 5'b00110, 5'b00111, 5'b11001})
                         || (sys_i && op == 5'b11100)) begin
                e.typ = 6'b010000;
                v = longint'(ins[31:20]);
                if (ins[31]) v = v - 4096;
            end else if (op inside {5'b01000, 5'b01001}) begin
                e.typ = 6'b001000;
                v = longint'({ins[31:25], ins[11:7]});
                if (ins[31]) v = v - 4096;
            end else if (op == 5'b11000) begin
                e.typ = 6'b000100;
                v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                if (ins[31]) v = v - 8192;
            end else if (op inside {5'b00101, 5'b01101}) begin
                e.typ = 6'b000010;
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v = v - (longint'(1) << 32);
            end else if (op == 5'b11011) begin
                e.typ = 6'b000001;
                v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                if (ins[31]) v = v - (longint'(1) << 21);
            end
        end
        e.illegal = (e.typ == 6'b000000);
        e.imm     = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
        return e;
    endfunction

    function automatic int cls(exp_t e);
        if (e.illegal) return 6;
        for (int k = 0; k < 6; k++) if (e.typ[5-k]) return k;
        return 6;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: occupancy is the number accepted but not yet delivered.
    always @(posedge clk) begin
        bit acc;
        acc = in_valid && (q.size() < 2);
        if (rst) begin
            q.delete();
            for (int k = 0; k < 7; k++) begin m32[k] = 0; m64[k] = 0; end
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) begin
                m32[cls(model(q[0].ins, 1'b1, 32))]++;
                m64[cls(model(q[0].ins, 1'b0, 64))]++;
                void'(q.pop_front());
            end
            if (acc) q.push_back('{ins: in_instr, pc: in_pc});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            chk("v32_valid", r32_valid, q.size() > 0);
            chk("v32_ready", r32_ready, q.size() < 2);
            chk("v64_valid", r64_valid, q.size() > 0);
            chk("v64_ready", r64_ready, q.size() < 2);
            if (q.size() > 0) begin
                e = model(q[0].ins, 1'b1, 32);
                chk("m32_pc", r32_pc, q[0].pc[31:0]);
                chk("m32_type", r32_type, e.typ);
                chk("m32_ill", r32_ill, e.illegal);
                chk("m32_imm", r32_imm, e.imm);
                chk("m32_regs", {r32_rd, r32_rs1, r32_rs2},
                    {q[0].ins[11:7], q[0].ins[19:15], q[0].ins[24:20]});
                chk("m32_funct", {r32_f7, r32_f3}, {q[0].ins[31:25], q[0].ins[14:12]});
                e = model(q[0].ins, 1'b0, 64);
                chk("m64_pc", r64_pc, q[0].pc);
                chk("m64_type", r64_type, e.typ);
                chk("m64_ill", r64_ill, e.illegal);
                chk("m64_imm", r64_imm, e.imm);
                chk("m64_regs", {r64_rd, r64_rs1, r64_rs2},
                    {q[0].ins[11:7], q[0].ins[19:15], q[0].ins[24:20]});
                chk("m64_funct", {r64_f7, r64_f3}, {q[0].ins[31:25], q[0].ins[14:12]});
            end
`ifdef DECODE_STATS_EN
            for (int k = 0; k < 7; k++) begin
                chk("stat32", s32[k], m32[k]);
                chk("stat64", s64[k], m64[k]);
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction through an empty pipe with out_ready=1; returns with it on out_*.
    task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] tbl [12];

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_instr = 32'd0; in_pc = 64'd0; out_ready = 1'b1;
        tbl = '{32'h002081B3, 32'hFFF00093, 32'h0020A423, 32'h123452B7,
                32'hFFDFF0EF, 32'h00208463, 32'h00000073, 32'h00000000,
                32'h40B50533, 32'h8000006F, 32'hFE000FA3, 32'hFE208EE3};
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", r32_valid, 1'b0);
        chk("rst_ready", r32_ready, 1'b1);
        chk("rst_data32", {r32_pc, r32_imm, r32_type, r32_ill}, 64'd0);
        chk("rst_data64", r64_imm | r64_pc, 64'd0);

        issue(32'h002081B3, 64'h1000);
        chk("add_type", r32_type, 6'b100000);
        chk("add_regs", {r32_rd, r32_rs1, r32_rs2}, {5'd3, 5'd1, 5'd2});
        chk("add_funct", {r32_f7, r32_f3}, 10'd0);
        chk("add_imm", r32_imm, 32'd0);
        chk("add_pc", r32_pc, 32'h1000);
        issue(32'hFFF00093, 64'h1004);
        chk("addi_type", r32_type, 6'b010000);
        chk("addi_imm32", r32_imm, 32'hFFFF_FFFF);
        chk("addi_imm64", r64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(32'h0020A423, 64'h1008);
        chk("sw_type", r32_type, 6'b001000);
        chk("sw_imm", r32_imm, 32'd8);
        issue(32'h123452B7, 64'h100C);
        chk("lui_type", r32_type, 6'b000010);
        chk("lui_imm", r64_imm, 64'h1234_5000);
        issue(32'hFFDFF0EF, 64'h1010);
        chk("jal_type", r32_type, 6'b000001);
        chk("jal_rd", r32_rd, 5'd1);
        chk("jal_imm32", r32_imm, 32'hFFFF_FFFC);
        chk("jal_imm64", r64_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        issue(32'h00208463, 64'h1014);
        chk("beq_type", r32_type, 6'b000100);
        chk("beq_imm", r32_imm, 32'd8);
        issue(32'h00000000, 64'h1018);
        chk("zero_ill", r32_ill, 1'b1);
        chk("zero_type", r32_type, 6'b000000);
        chk("zero_imm", r32_imm, 32'd0);
        issue(32'h00000073, 64'h101C);
        chk("sys_as_i", {r32_ill, r32_type}, {1'b0, 6'b010000});
        chk("sys_illegal", {r64_ill, r64_type}, {1'b1, 6'b000000});
        step();

        // Backpressure: two held, third refused, then drained in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 64'h100; step();
        in_instr = 32'h00200313; in_pc = 64'h104; step();
        chk("bp_ready_low", r32_ready, 1'b0);
        in_instr = 32'h00300393; in_pc = 64'h108; step();
        chk("bp_ready_held", r32_ready, 1'b0);
        chk("bp_stable_pc", r32_pc, 32'h100);
        out_ready = 1'b1; step();
        chk("bp_second", r32_pc, 32'h104);
        step();
        in_valid = 1'b0;
        chk("bp_third", r32_pc, 32'h108);
        step();
        chk("bp_empty", r32_valid, 1'b0);

        // Flush with both registers full and a same-cycle input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h200; step();
        in_pc = 64'h204; step();
        flush = 1'b1; in_pc = 64'h208; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", r32_valid, 1'b0);
        chk("flush_ready", r32_ready, 1'b1);
        out_ready = 1'b1; step();
        chk("flush_dropped", r64_valid, 1'b0);

        // Randomised traffic over the directed table plus raw words.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = ($urandom_range(0, 4) == 0) ? $urandom : tbl[$urandom_range(0, 11)];
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 50) == 0);
            step();
        end
        flush = 1'b0;

        // Reset with both registers full and a same-cycle input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h300; step();
        in_pc = 64'h304; step();
        rst = 1'b1; in_pc = 64'h308; step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst2_valid", r64_valid, 1'b0);
        chk("rst2_ready", r64_ready, 1'b1);
        chk("rst2_data", r64_imm | r64_pc, 64'd0);
`ifdef DECODE_STATS_EN
        chk("rst2_stat_i", s32[1], 32'd0);
        chk("rst2_stat_ill", s64[6], 32'd0);
`endif
        out_ready = 1'b1;
        repeat (3) step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32/RV64 instruction decode stage with a valid/ready handshake on both sides.
- Classifies each instruction into one format (R/I/S/B/U/J) and extracts register indices, funct fields and the sign-extended immediate.
- Flags illegal encodings.
- Sits between fetch and register-read. Includes a one-entry skid buffer so it sustains one instruction per cycle under backpressure.

Parameters:
- XLEN, 32, datapath width for the immediate and PC (32 or 64 only).
- SYSTEM_AS_I, 1, when 1, opcode[6:2]=11100 is classified as I-type; when 0, it is flagged illegal.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of every held instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passed-through PC.
- out_type  out  6  one-hot format, {r,i,s,b,u,j}, bit5=r; all zero when illegal.
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type and illegal.
- out_illegal  out  1  encoding not recognised.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0; skid buffer empty; in_ready=1 from the next cycle.
  - All data outputs are 0.
  - Reset mid-transfer drops the in-flight instruction with no partial output.
- Classification uses op=in_instr[6:2]:
  - R: 01100, 01011, 01110, 10100.
  - I: 00000, 00001, 00010, 00011, 00100, 00110, 00111, 11001, and 11100 when SYSTEM_AS_I=1.
  - S: 01000, 01001.
  - B: 11000.
  - U: 00101, 01101.
  - J: 11011.
  - Illegal: instr[1:0]!=2'b11, or op matches none of the above.
  - Exactly one out_type bit is set for a legal instruction.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Pipeline: output register (OR) plus skid register (SK).
  - Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
  - in_ready = !SK.valid (registered, no combinational path from out_ready).
  - Accept occurs when in_valid && in_ready.
  - Output handshake occurs when out_valid && out_ready.
- Transitions per edge:
  - OR empty or draining, SK empty: an accepted instruction goes to OR.
  - OR held (out_ready=0), SK empty: an accepted instruction goes to SK, and in_ready drops next cycle.
  - OR draining, SK full: SK moves to OR, SK empties, and in_ready rises next cycle.
  - Order is preserved; no instruction is dropped or duplicated.
- out_* fields are stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - OR and SK are invalidated, and any same-cycle input is discarded.
  - flush has priority over accept and handshake; rst has priority over flush.
- Decoding is purely field extraction: no register-file access and no instruction-specific funct checks.

Optional Feature:
- Macro: DECODE_STATS_EN.
- When defined:
  - Adds output ports stat_count_r, stat_count_i, stat_count_s, stat_count_b, stat_count_u, stat_count_j and stat_count_illegal, each 32 bits.
  - Each counter increments on an output handshake of its class.
  - Counters saturate at 0xFFFFFFFF and clear only on rst (not on flush).
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 -> one cycle later: out_type=100000, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, imm=0.
- 0xFFF00093 (addi x1,x0,-1) with XLEN=32, then XLEN=64 -> I-type; imm=0xFFFFFFFF and 0xFFFFFFFFFFFFFFFF respectively.
- 0x0020A423 (sw) -> S, imm=8; 0x123452B7 (lui) -> U, imm=0x12345000; 0xFFDFF0EF (jal) -> J, rd=1, imm=0xFFFFFFFC.
- out_ready=0, stream 3 back-to-back valid instructions -> first two accepted, in_ready=0 at the third; raise out_ready -> all three emerge in order on consecutive cycles.
- Illegal encodings: 0x00000000 -> out_illegal=1, out_type=0, imm=0; 0x00000073 with SYSTEM_AS_I=0 -> illegal.
- Flush and reset: with OR and SK full, pulse flush together with in_valid=1 -> out_valid=0 next cycle and in_ready=1. Repeat with rst -> same result, and the DECODE_STATS_EN counters read 0.
